// File: rtl/pipe_rca_adder_if.sv
// Operand/result handshake bundle for pipe_rca_adder.
// The master is the side that supplies operands and consumes results.
interface pipe_rca_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder: one CHUNK-bit slice resolved per register stage,
// carry handed stage to stage, valid/ready at both ends, signed or unsigned overflow.
module pipe_rca_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4,
  parameter int SIGNED = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_rca_adder_if.slave bus
);

  localparam int CHUNK = WIDTH / STAGES;

  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  // Operands travel whole; only the chunks above stage k are still consumed.
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] s_p   [STAGES];
  logic             c_p   [STAGES];
  logic             vld_p [STAGES];

  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];
  logic             ld    [STAGES];
  logic [WIDTH-1:0] nxt_s [STAGES];
  logic             nxt_c [STAGES];
  logic [CHUNK:0]   part;
  logic             adv;
  logic             msb_ci;

  assign adv = bus.out_ready | ~vld_p[STAGES-1];

  always_comb begin
    part     = '0;
    src_a[0] = bus.a;
    src_b[0] = bus.b;
    src_s[0] = '0;
    src_c[0] = bus.cin;
    ld[0]    = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_p[k-1];
      src_b[k] = b_p[k-1];
      src_s[k] = s_p[k-1];
      src_c[k] = c_p[k-1];
      ld[k]    = vld_p[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      part     = chunk_add(src_a[k][k*CHUNK +: CHUNK], src_b[k][k*CHUNK +: CHUNK], src_c[k]);
      nxt_s[k] = src_s[k];
      nxt_s[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      nxt_c[k] = part[CHUNK];
    end
  end

  // Stage registers: all advance together; a bubble leaves its stage's data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= 1'b0;
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        s_p[k]   <= '0;
        c_p[k]   <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= ld[k];
        if (ld[k]) begin
          a_p[k] <= src_a[k];
          b_p[k] <= src_b[k];
          s_p[k] <= nxt_s[k];
          c_p[k] <= nxt_c[k];
        end
      end
    end
  end

  // Final stage: carry into the MSB recovered from the stored MSB operands and sum.
  assign msb_ci = a_p[STAGES-1][WIDTH-1] ^ b_p[STAGES-1][WIDTH-1] ^ s_p[STAGES-1][WIDTH-1];

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_p[STAGES-1];
  assign bus.sum       = s_p[STAGES-1];
  assign bus.cout      = c_p[STAGES-1];
  assign bus.ovf       = (SIGNED != 0) ? (msb_ci ^ c_p[STAGES-1]) : c_p[STAGES-1];

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Directed and randomised checks of pipe_rca_adder (WIDTH=16) over several
// STAGES/SIGNED configurations.
module tb_pipe_rca_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf_u;
    logic        ovf_s;
  } tv_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   rand_go = 1'b0;
  int   rand_fin = 0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  pipe_rca_adder_if #(.WIDTH(16)) if0 ();
  pipe_rca_adder_if #(.WIDTH(16)) if1 ();

  pipe_rca_adder #(.WIDTH(16), .STAGES(4), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  pipe_rca_adder #(.WIDTH(16), .STAGES(4), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input int sg);
    exp_t        e;
    logic [16:0] f;
    f      = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    e.sum  = f[15:0];
    e.cout = f[16];
    e.ovf  = (sg != 0) ? ((a[15] == b[15]) && (f[15] != a[15])) : f[16];
    return e;
  endfunction

  task automatic drive(input logic v, input tv_t t, input logic ordy);
    if0.in_valid = v; if0.a = t.a; if0.b = t.b; if0.cin = t.cin; if0.out_ready = ordy;
    if1.in_valid = v; if1.a = t.a; if1.b = t.b; if1.cin = t.cin; if1.out_ready = ordy;
  endtask

  task automatic chk_out(input string pfx, input tv_t e);
    chk({pfx, "_sum"},  if0.sum,  e.sum);
    chk({pfx, "_cout"}, if0.cout, e.cout);
    chk({pfx, "_ovfu"}, if0.ovf,  e.ovf_u);
    chk({pfx, "_ssum"}, if1.sum,  e.sum);
    chk({pfx, "_ovfs"}, if1.ovf,  e.ovf_s);
  endtask

  // Random regression instances: STAGES in {1,2,4,16} x SIGNED in {0,1}
  for (genvar g = 0; g < 8; g++) begin : g_rand
    localparam int ST = (g % 4 == 0) ? 1 : (g % 4 == 1) ? 2 : (g % 4 == 2) ? 4 : 16;
    localparam int SG = g / 4;
    pipe_rca_adder_if #(.WIDTH(16)) rif ();
    pipe_rca_adder #(.WIDTH(16), .STAGES(ST), .SIGNED(SG)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(rif.slave));
    exp_t q[$];

    initial begin
      exp_t e;
      rif.in_valid = 1'b0; rif.a = '0; rif.b = '0; rif.cin = 1'b0; rif.out_ready = 1'b0;
      wait (rand_go);
      for (int cyc = 0; cyc < 600; cyc++) begin
        @(negedge clk);
        if (cyc < 400) begin
          rif.in_valid  = 1'($urandom_range(0, 1));
          rif.a         = 16'($urandom);
          rif.b         = 16'($urandom);
          rif.cin       = 1'($urandom_range(0, 1));
          rif.out_ready = ($urandom_range(0, 3) != 0);
        end else begin
          rif.in_valid  = 1'b0;
          rif.out_ready = 1'b1;
        end
        #1;
        if (rif.in_valid && rif.in_ready) q.push_back(model(rif.a, rif.b, rif.cin, SG));
        if (rif.out_valid && rif.out_ready) begin
          if (q.size() == 0) begin
            chk($sformatf("rnd%0d_extra", g), 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk($sformatf("rnd%0d_sum", g),  rif.sum,  e.sum);
            chk($sformatf("rnd%0d_cout", g), rif.cout, e.cout);
            chk($sformatf("rnd%0d_ovf", g),  rif.ovf,  e.ovf);
          end
        end
      end
      chk($sformatf("rnd%0d_left", g), q.size(), 0);
      rand_fin++;
    end
  end

  tv_t tv[12];
  tv_t idle;

  initial begin
    int  lat;
    int  idx;
    int  got;
    bit  acc;
    bit  stale;

    tv[0]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    tv[1]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1};
    tv[2]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b1};
    tv[3]  = '{16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
    tv[6]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tv[9]  = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1};
    tv[10] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    tv[11] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0};
    idle   = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

    drive(1'b0, idle, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset state
    @(negedge clk); #1;
    chk("rst_out_valid", if0.out_valid, 1'b0);
    chk("rst_sum",       if0.sum,       16'h0000);
    chk("rst_cout",      if0.cout,      1'b0);
    chk("rst_ovf",       if1.ovf,       1'b0);
    chk("rst_in_ready",  if0.in_ready,  1'b1);

    // One add at a time: latency and result fields
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1'b1, tv[i], 1'b1);
      #1 chk($sformatf("tv%0d_in_ready", i), if0.in_ready, 1'b1);
      @(negedge clk);
      drive(1'b0, idle, 1'b1);
      lat = 1;
      #1;
      while (!if0.out_valid && lat < 10) begin
        @(negedge clk); #1;
        lat++;
      end
      chk($sformatf("tv%0d_latency", i), lat, 4);
      chk_out($sformatf("tv%0d", i), tv[i]);
    end

    // Back-to-back accepts, results on consecutive cycles
    for (int i = 3; i < 6; i++) begin
      @(negedge clk);
      drive(1'b1, tv[i], 1'b1);
      #1 chk($sformatf("thr%0d_in_ready", i), if0.in_ready, 1'b1);
    end
    @(negedge clk);
    drive(1'b0, idle, 1'b1);
    for (int i = 3; i < 6; i++) begin
      @(negedge clk); #1;
      chk($sformatf("thr%0d_out_valid", i), if0.out_valid, 1'b1);
      chk_out($sformatf("thr%0d", i), tv[i]);
    end
    @(negedge clk); #1;
    chk("thr_empty", if0.out_valid, 1'b0);

    // Backpressure: fill with out_ready low, stall, then drain in order
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1'b1, tv[6 + idx], 1'b0);
      #1 acc = if0.in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    chk("bp_fill_count", idx, 4);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      drive(1'b1, tv[10], 1'b0);
      #1;
      chk($sformatf("bp_stall%0d_in_ready", s),  if0.in_ready,  1'b0);
      chk($sformatf("bp_stall%0d_out_valid", s), if0.out_valid, 1'b1);
      chk($sformatf("bp_stall%0d_sum", s),       if0.sum,       tv[6].sum);
      chk($sformatf("bp_stall%0d_cout", s),      if0.cout,      tv[6].cout);
    end
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      @(negedge clk);
      drive(idx < 5, tv[6 + ((idx < 5) ? idx : 4)], 1'b1);
      #1;
      acc = if0.in_valid && if0.in_ready;
      if (if0.out_valid) begin
        chk($sformatf("bp_drain%0d_sum", got), if0.sum, tv[6 + got].sum);
        got++;
      end
      @(posedge clk);
      if (acc) idx++;
    end
    chk("bp_drain_count", got, 5);
    @(negedge clk);
    drive(1'b0, idle, 1'b1);

    // Reset mid-flight with a result waiting at the output
    for (int i = 7; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, tv[i], 1'b1);
    end
    @(negedge clk);
    drive(1'b0, idle, 1'b0);
    @(posedge clk); #2;
    chk("mid_pre_valid", if0.out_valid, 1'b1);
    chk("mid_pre_sum",   if0.sum,       tv[7].sum);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",    if0.out_valid, 1'b0);
    chk("mid_rst_sum",      if0.sum,       16'h0000);
    chk("mid_rst_cout",     if0.cout,      1'b0);
    chk("mid_rst_in_ready", if0.in_ready,  1'b1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(1'b0, idle, 1'b1);
      #1 if (if0.out_valid || if1.out_valid) stale = 1'b1;
    end
    chk("mid_no_stale", stale, 1'b0);

    // Random regression across configurations
    rand_go = 1'b1;
    for (int c = 0; c < 3000 && rand_fin < 8; c++) @(posedge clk);
    chk("rand_finished", rand_fin, 8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pipe_rca_adder.md
Name: pipe_rca_adder

Overview:
- Parametrised, pipelined ripple-carry adder: the multi-bit, registered successor of the team's single-bit full adder.
- Splits a WIDTH-bit add into STAGES chunks. Each chunk is resolved in its own register stage, and the carry is passed stage to stage.
- Has a valid/ready handshake at both ends and signed-overflow reporting.
- Sits in arithmetic datapaths that need full throughput (one add per clock) at a clock rate a single-cycle WIDTH-bit ripple chain cannot meet.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be an integer multiple of STAGES.
- STAGES, 4, pipeline depth; CHUNK = WIDTH/STAGES bits resolved per stage; legal range 1..WIDTH.
- SIGNED, 0, 1 = ovf reports two's-complement overflow; 0 = ovf reports unsigned overflow (equal to cout).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on a/b/cin are valid
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry in to bit 0
- out_valid  output  1  sum/cout/ovf are valid
- out_ready  input  1  downstream accepts result this cycle
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  overflow flag per SIGNED

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous release on clk):
  - all stage valid bits clear → out_valid=0.
  - sum=0, cout=0, ovf=0, all internal operand/partial-sum/carry registers 0.
  - in_ready=1 once reset is released.
- Pipeline advance:
  - adv = out_ready | ~out_valid.
  - in_ready = adv (combinational).
  - All stages shift together when adv=1 and hold when adv=0.
  - Bubbles are not collapsed.
- Input transfer occurs on in_valid & in_ready. Stage-0 valid loads in_valid whenever adv=1.
- Stage k (0..STAGES-1):
  - adds chunk k of the carried operands plus the carry from stage k-1 (cin for k=0);
  - registers the CHUNK-bit partial sum, the chunk carry, the untouched upper operand chunks, and the already-resolved lower partial sums.
  - Operand skew: the upper chunks ride along in the stage registers until consumed.
- Latency: an accepted transfer at edge N produces out_valid=1 with its result after edge N+STAGES-1 (i.e., visible STAGES cycles after acceptance), provided no stall occurs.
- Throughput: one result per clock with out_ready held high.
- Output stability: while out_valid=1 and out_ready=0, sum/cout/ovf/out_valid hold exactly and no input is accepted.
- Result fields:
  - cout = carry from the top chunk.
  - SIGNED=1: ovf = carry into MSB XOR carry out of MSB; computed inside the final stage.
  - SIGNED=0: ovf = cout.
- When out_valid=0, sum/cout/ovf hold their last value; they carry no meaning.
- STAGES=1 degenerates to a registered single-cycle adder with the same handshake.
- Ordering: results leave in acceptance order; no reordering, no drop, no duplication.
- Reset mid-operation flushes every in-flight add. No result from before reset appears afterwards.
- Simultaneous output pop and input accept in the same cycle is legal and required for full throughput.

Test Plan (WIDTH=16, STAGES=4 unless stated):
- Carry ripple across all chunks: a=0xFFFF, b=0x0001, cin=0, out_ready=1 → after 4 cycles sum=0x0000, cout=1, ovf=1 (SIGNED=0).
- Signed overflow, SIGNED=1:
  - 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1.
  - 0x8000+0xFFFF → sum=0x7FFF, cout=1, ovf=1.
  - 0xFFFF+0x0001 → ovf=0.
- Full throughput: back-to-back pairs (1,2,cin=1), (0x00FF,0x0F01,0), (0xAAAA,0x5555,1), with out_ready=1 → results 0x0004, 0x1000, 0x0000/cout=1 on three consecutive cycles, starting 4 cycles after the first accept.
- Backpressure:
  - Fill the pipe, then drop out_ready for 3 cycles → in_ready=0 and outputs frozen for those cycles.
  - Raise out_ready → remaining results drain in order with no loss.
- Reset mid-flight: accept 3 adds, assert rst_n=0 for 1 cycle (asynchronous, between edges) → out_valid=0 and sum=0 immediately; no stale result appears after release.
- Random regression against a reference model across STAGES ∈ {1,2,4,16} and both SIGNED values, with random in_valid/out_ready → every result matches a+b+cin and order is preserved.
